// File: rtl/instr_dispatch_pkg.sv
// Shared definitions for the instruction dispatcher.
//   - state_e      : dispatcher FSM states (ST_ERR exists only with DISPATCH_TIMEOUT_EN)
//   - OP_*         : opcode constants and the ALU/immediate range boundary
//   - *_MSB/*_LSB  : bit positions of the fields inside instr_word
//   - TIMEOUT_MAX  : WAIT-state timeout limit (used with DISPATCH_TIMEOUT_EN)
package instr_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
`ifdef DISPATCH_TIMEOUT_EN
    ,
    ST_ERR    = 3'd6
`endif
  } state_e;

  localparam logic [3:0] OP_NOP      = 4'b0000;
  localparam logic [3:0] OP_HALT     = 4'b1111;
  localparam logic [3:0] OP_IMM_BASE = 4'b1000;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned P1_MSB  = 27;
  localparam int unsigned P1_LSB  = 22;
  localparam int unsigned P2_MSB  = 21;
  localparam int unsigned P2_LSB  = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

endpackage

// File: rtl/instr_dispatch_decode.sv
// Combinational opcode classifier for the dispatcher.
// Ports:
//   opcode  : 4-bit latched opcode
//   is_nop  : opcode is NOP
//   is_halt : opcode is HALT
//   sel_alu : opcode routes to the register-register ALU FSM (0001-0111)
//   sel_imm : opcode routes to the immediate ALU FSM (1000-1110)
module dispatch_decode
  import instr_dispatch_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_nop,
  output logic       is_halt,
  output logic       sel_alu,
  output logic       sel_imm
);

  always_comb begin
    is_nop  = (opcode == OP_NOP);
    is_halt = (opcode == OP_HALT);
    sel_alu = !is_nop  && (opcode <  OP_IMM_BASE);
    sel_imm = !is_halt && (opcode >= OP_IMM_BASE);
  end

endmodule

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: fetches a 32-bit word, latches its fields, starts the
// matching ALU FSM with a one-cycle pulse and waits for that FSM's done.
// Optional feature: define DISPATCH_TIMEOUT_EN to add a WAIT timeout that
// moves to a sticky error state; otherwise error is tied low.
// Ports:
//   clock, reset(async, active-low), run(level enable)
//   instr_valid/instr_word in, instr_ready out (high only in FETCH)
//   opcode/param1/param2/immediate : latched instruction fields
//   alu_FSM_start/imm_FSM_start    : one-cycle start pulses
//   alu_done/imm_done              : completion inputs
//   pc (instruction count, wraps), halted, error
module instr_dispatch
  import instr_dispatch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        instr_valid,
  input  logic [31:0] instr_word,
  output logic        instr_ready,
  output logic [3:0]  opcode,
  output logic [5:0]  param1,
  output logic [5:0]  param2,
  output logic [15:0] immediate,
  output logic        alu_FSM_start,
  output logic        imm_FSM_start,
  input  logic        alu_done,
  input  logic        imm_done,
  output logic [7:0]  pc,
  output logic        halted,
  output logic        error
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [5:0]  param1_q, param1_d;
  logic [5:0]  param2_q, param2_d;
  logic [15:0] immediate_q, immediate_d;
`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic is_nop, is_halt, sel_alu, sel_imm;
  logic sel_done;

  // Fields stay stable from DECODE until the next acceptance, so decoding the
  // latched opcode directly is valid through START and WAIT.
  dispatch_decode u_decode (
    .opcode  (opcode_q),
    .is_nop  (is_nop),
    .is_halt (is_halt),
    .sel_alu (sel_alu),
    .sel_imm (sel_imm)
  );

  // Only the selected FSM's done counts; the other is ignored.
  assign sel_done = sel_alu ? alu_done : imm_done;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    opcode_d    = opcode_q;
    param1_d    = param1_q;
    param2_d    = param2_q;
    immediate_d = immediate_q;
`ifdef DISPATCH_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (instr_valid) begin
          opcode_d    = instr_word[OPC_MSB:OPC_LSB];
          param1_d    = instr_word[P1_MSB:P1_LSB];
          param2_d    = instr_word[P2_MSB:P2_LSB];
          immediate_d = instr_word[IMM_MSB:IMM_LSB];
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_nop) begin
          pc_d    = pc_q + 8'd1;
          state_d = ST_FETCH;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (sel_done) begin
          pc_d    = pc_q + 8'd1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          // Counter reaches TIMEOUT_MAX on this edge: 255 WAIT cycles elapsed.
          if (cnt_q == TIMEOUT_MAX - 8'd1) state_d = ST_ERR;
        end
`endif
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
`ifdef DISPATCH_TIMEOUT_EN
      ST_ERR: begin
        state_d = ST_ERR;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      opcode_q    <= '0;
      param1_q    <= '0;
      param2_q    <= '0;
      immediate_q <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      opcode_q    <= opcode_d;
      param1_q    <= param1_d;
      param2_q    <= param2_d;
      immediate_q <= immediate_d;
`ifdef DISPATCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Outputs are decoded from registered state so reset clears them at once.
  assign instr_ready   = (state_q == ST_FETCH);
  assign alu_FSM_start = (state_q == ST_START) && sel_alu;
  assign imm_FSM_start = (state_q == ST_START) && sel_imm;
  assign halted        = (state_q == ST_HALT);
  assign opcode        = opcode_q;
  assign param1        = param1_q;
  assign param2        = param2_q;
  assign immediate     = immediate_q;
  assign pc            = pc_q;
`ifdef DISPATCH_TIMEOUT_EN
  assign error         = (state_q == ST_ERR);
`else
  assign error         = 1'b0;
`endif

endmodule

// File: doc/instr_dispatch.md
INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
- REQ-001 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
- REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- REQ-003 SHALL have port: run  input  1  level enable; 1 allows fetching.
- REQ-004 SHALL have port: instr_valid  input  1  instruction source holds a word.
- REQ-005 SHALL have port: instr_word  input  32  [31:28] opcode, [27:22] param1, [21:16] param2, [15:0] immediate.
- REQ-006 SHALL have port: instr_ready  output  1  dispatcher accepts instr_word this cycle.
- REQ-007 SHALL have ports: opcode  output  4; param1  output  6; param2  output  6; immediate  output  16; all hold the latched instruction fields.
- REQ-008 SHALL have ports: alu_FSM_start  output  1; imm_FSM_start  output  1; each is the one-cycle FSM_start pulse to the register-register and immediate ALU FSMs.
- REQ-009 SHALL have ports: alu_done  input  1; imm_done  input  1; these are the done signals from those FSMs.
- REQ-010 SHALL have ports: pc  output  8  instruction count; halted  output  1; error  output  1.

Function
- REQ-011 SHALL implement states IDLE, FETCH, DECODE, START, WAIT, HALT, ERR.
- REQ-012 IDLE SHALL go to FETCH when run=1 and otherwise stay in IDLE.
- REQ-013 FETCH SHALL drive instr_ready=1 and, on instr_valid=1, latch all four fields and go to DECODE; with instr_valid=0 it SHALL stay in FETCH.
- REQ-014 DECODE SHALL take exactly one cycle: opcode 0000 (NOP) increments pc and goes to FETCH; 1111 (HALT) goes to HALT; 0001-0111 selects the ALU FSM; 1000-1110 selects the immediate FSM; both selections go to START.
- REQ-015 START SHALL assert exactly one start output, for the selected FSM only, for exactly one cycle, then go to WAIT.
- REQ-016 WAIT SHALL leave on the selected FSM's done=1, increment pc, and go to FETCH if run=1 or IDLE if run=0.
- REQ-017 A done from the non-selected FSM, or any done outside WAIT, SHALL be ignored.
- REQ-018 Latency from instr_valid acceptance to start pulse SHALL be exactly 2 cycles (DECODE, START).
- REQ-019 pc SHALL wrap from 255 to 0 with no flag.
- REQ-020 HALT SHALL drive halted=1 and instr_ready=0 and SHALL stay in HALT until reset; run is ignored.
- REQ-021 Latched fields SHALL hold stable from DECODE until the next FETCH acceptance.
- REQ-022 Dropping run mid-instruction SHALL NOT abort that instruction; the dispatcher returns to IDLE only after done.

Reset
- REQ-023 Reset assertion SHALL immediately force IDLE, clear pc, all fields, both start outputs, halted, error and the timeout counter, and drive instr_ready=0.
- REQ-024 Reset during WAIT SHALL abandon the instruction; a late done SHALL be ignored per REQ-017.

Configuration
- REQ-025 With DISPATCH_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; when it reaches 255 without done, the dispatcher SHALL go to ERR, set error=1 and hold instr_ready=0, sticky until reset.
- REQ-026 Without DISPATCH_TIMEOUT_EN, WAIT SHALL wait indefinitely, the ERR state and counter SHALL not exist, and error SHALL be tied to 0.

Structure
- REQ-027 A shared package SHALL hold: the state enumeration; opcode constants OP_NOP=4'b0000 and OP_HALT=4'b1111; range boundaries OP_IMM_BASE=4'b1000; the instruction field bit positions; and TIMEOUT_MAX=255.
- REQ-028 One sub-module, dispatch_decode, SHALL be purely combinational and map opcode to {is_nop, is_halt, sel_alu, sel_imm}.

Verification
- REQ-029 run=1, word with opcode 0011, param1=1, param2=2 -> alu_FSM_start high exactly 2 cycles after acceptance, fields hold 3/1/2; alu_done pulse -> pc 0->1, instr_ready=1 next cycle.
- REQ-030 Opcode 1001, immediate 16'hBEEF -> imm_FSM_start pulses once, alu_FSM_start stays 0; an alu_done pulse during WAIT is ignored; imm_done completes the instruction.
- REQ-031 NOP then HALT -> pc=1, no start pulse, halted=1; further instr_valid and run toggles leave the state unchanged.
- REQ-032 pc preset by issuing 255 NOPs, then one more -> pc=0.
- REQ-033 reset driven to 0 in WAIT mid-cycle -> outputs clear asynchronously; a later done is ignored and pc stays 0.
- REQ-034 DISPATCH_TIMEOUT_EN defined, done withheld -> error=1 after 255 WAIT cycles; with the macro undefined, error stays 0 indefinitely.
